// File: rtl/conv_maxpool_if.sv
// Stream bundle for conv_maxpool: raster input samples in, pooled samples out.
// The slave modport faces the pooling block. The master modport faces the producer/consumer.
interface conv_maxpool_if #(
    parameter int DATA_W = 16
);
    logic signed [DATA_W-1:0] in_data;
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] out_data;
    logic                     out_valid;
    logic                     out_ready;
    logic                     frame_done;
    logic [15:0]              out_row;
    logic [15:0]              out_col;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, frame_done, out_row, out_col
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, frame_done, out_row, out_col
    );
endinterface

// File: rtl/conv_maxpool.sv
// 2x2 stride-2 signed max pooling over a raster stream, using one line buffer of partial maxima.
// Optional macro CONV_MAXPOOL_RELU_EN clamps negative inputs to zero before pooling.
module conv_maxpool #(
    parameter int OUT    = 126,
    parameter int DATA_W = 16
) (
    input  logic          clk,
    input  logic          rst,
    conv_maxpool_if.slave bus
);
    localparam int          POOL_OUT  = OUT / 2;
    localparam int          IDX_W     = (POOL_OUT > 1) ? $clog2(POOL_OUT) : 1;
    localparam logic [15:0] LAST_IDX  = 16'(OUT - 1);
    localparam logic [15:0] LAST_POOL = 16'(POOL_OUT - 1);
    localparam bit          ODD_OUT   = (OUT % 2) == 1;

    function automatic logic signed [DATA_W-1:0] smax(
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

    logic                     run_r;
    logic [15:0]              row_r;
    logic [15:0]              col_r;
    logic signed [DATA_W-1:0] pair_r;
    logic signed [DATA_W-1:0] linebuf_r [POOL_OUT];
    logic signed [DATA_W-1:0] out_data_r;
    logic                     out_valid_r;
    logic [15:0]              out_row_r;
    logic [15:0]              out_col_r;
    logic                     frame_done_r;

    logic                     in_ready_s;
    logic                     accept_s;
    logic                     out_acc_s;
    logic                     tail_s;
    logic                     lb_we_s;
    logic                     win_done_s;
    logic [IDX_W-1:0]         lb_idx_s;
    logic signed [DATA_W-1:0] x_s;
    logic signed [DATA_W-1:0] lb_rd_s;
    logic signed [DATA_W-1:0] pair_max_s;
    logic signed [DATA_W-1:0] win_max_s;

    // Handshake, window decode and max datapath
    always_comb begin
        in_ready_s = run_r && !(out_valid_r && !bus.out_ready);
        accept_s   = bus.in_valid && in_ready_s;
        out_acc_s  = out_valid_r && bus.out_ready;
`ifdef CONV_MAXPOOL_RELU_EN
        if (bus.in_data[DATA_W-1]) begin
            x_s = {DATA_W{1'b0}};
        end else begin
            x_s = bus.in_data;
        end
`else
        x_s = bus.in_data;
`endif
        // With an odd side, the last column and the last row have no pooling partner.
        tail_s     = ODD_OUT && ((col_r == LAST_IDX) || (row_r == LAST_IDX));
        lb_idx_s   = col_r[IDX_W:1];
        lb_rd_s    = linebuf_r[lb_idx_s];
        pair_max_s = smax(pair_r, x_s);
        win_max_s  = smax(lb_rd_s, pair_max_s);
        lb_we_s    = accept_s && !tail_s && col_r[0] && !row_r[0];
        win_done_s = accept_s && !tail_s && col_r[0] && row_r[0];
    end

    assign bus.in_ready   = in_ready_s;
    assign bus.out_data   = out_data_r;
    assign bus.out_valid  = out_valid_r;
    assign bus.out_row    = out_row_r;
    assign bus.out_col    = out_col_r;
    assign bus.frame_done = frame_done_r;

    // Input enable and raster position counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_r <= 1'b0;
            row_r <= 16'd0;
            col_r <= 16'd0;
        end else begin
            run_r <= 1'b1;
            if (accept_s) begin
                if (col_r == LAST_IDX) begin
                    col_r <= 16'd0;
                    row_r <= (row_r == LAST_IDX) ? 16'd0 : row_r + 16'd1;
                end else begin
                    col_r <= col_r + 16'd1;
                end
            end
        end
    end

    // Holds the even-column sample until its odd-column partner arrives
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pair_r <= {DATA_W{1'b0}};
        end else if (accept_s && !col_r[0] && !tail_s) begin
            pair_r <= x_s;
        end
    end

    // Partial maxima of the even row, consumed by the following odd row
    always_ff @(posedge clk) begin
        if (lb_we_s) begin
            linebuf_r[lb_idx_s] <= pair_max_s;
        end
    end

    // Output register, valid hold until accepted, and end-of-frame pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_data_r   <= {DATA_W{1'b0}};
            out_valid_r  <= 1'b0;
            out_row_r    <= 16'd0;
            out_col_r    <= 16'd0;
            frame_done_r <= 1'b0;
        end else begin
            frame_done_r <= out_acc_s && (out_row_r == LAST_POOL) && (out_col_r == LAST_POOL);
            if (win_done_s) begin
                out_valid_r <= 1'b1;
                out_data_r  <= win_max_s;
                out_row_r   <= {1'b0, row_r[15:1]};
                out_col_r   <= {1'b0, col_r[15:1]};
            end else if (out_acc_s) begin
                out_valid_r <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_conv_maxpool.sv
// Scoreboard bench for conv_maxpool: OUT=4 and OUT=5 instances driven with directed frames.
module tb_conv_maxpool;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    conv_maxpool_if #(.DATA_W(16)) if4 ();
    conv_maxpool_if #(.DATA_W(16)) if5 ();

    conv_maxpool #(.OUT(4), .DATA_W(16)) u4 (.clk(clk), .rst(rst), .bus(if4.slave));
    conv_maxpool #(.OUT(5), .DATA_W(16)) u5 (.clk(clk), .rst(rst), .bus(if5.slave));

    typedef struct {
        logic signed [15:0] d;
        logic [15:0]        r;
        logic [15:0]        c;
    } exp_t;

    exp_t q [2][$];
    bit   fd_exp [2];
    int   fd_cnt [2];
    int   tests = 0;
    int   fails = 0;
    bit   bp_arm = 1'b0;

    function automatic logic signed [15:0] relu(input logic signed [15:0] v);
`ifdef CONV_MAXPOOL_RELU_EN
        return (v < 0) ? 16'sd0 : v;
`else
        return v;
`endif
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int k, input int v, input int r, input int c);
        exp_t e;
        e.d = relu(16'(v));
        e.r = 16'(r);
        e.c = 16'(c);
        q[k].push_back(e);
    endtask

    // Monitor step: pop and compare on each accepted output, and check frame_done timing
    task automatic mon_step(input int k, input logic ov, input logic ordy, input logic fd,
                            input logic signed [15:0] d, input logic [15:0] r, input logic [15:0] c);
        exp_t e;
        if (fd) fd_cnt[k]++;
        if (fd_exp[k]) begin
            check($sformatf("frame_done_u%0d", k), longint'(fd), 1);
            fd_exp[k] = 1'b0;
        end else if (fd) begin
            tests++;
            fails++;
            $display("FAIL spurious_frame_done_u%0d: got 1 expected 0 at %0t", k, $time);
        end
        if (ov && ordy) begin
            if (q[k].size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_output_u%0d: got %0d expected none", k, d);
            end else begin
                e = q[k].pop_front();
                check($sformatf("out_data_u%0d", k), longint'(d), longint'(e.d));
                check($sformatf("out_row_u%0d", k), longint'(r), longint'(e.r));
                check($sformatf("out_col_u%0d", k), longint'(c), longint'(e.c));
                if (r == 16'd1 && c == 16'd1) fd_exp[k] = 1'b1;
            end
        end
    endtask

    always @(negedge clk) begin
        mon_step(0, if4.out_valid, if4.out_ready, if4.frame_done, if4.out_data, if4.out_row, if4.out_col);
        mon_step(1, if5.out_valid, if5.out_ready, if5.frame_done, if5.out_data, if5.out_row, if5.out_col);
    end

    // Backpressure: stall the OUT=4 consumer for 5 cycles when output 5 appears
    always begin
        @(posedge clk);
        #1;
        if (bp_arm && if4.out_valid && if4.out_data == 16'sd5) begin
            bp_arm = 1'b0;
            if4.out_ready = 1'b0;
            repeat (5) begin
                @(negedge clk);
                check("bp_in_ready_low", longint'(if4.in_ready), 0);
                check("bp_out_valid_held", longint'(if4.out_valid), 1);
                check("bp_out_data_held", longint'(if4.out_data), 5);
                @(posedge clk);
            end
            #1;
            if4.out_ready = 1'b1;
            @(negedge clk);
            check("bp_in_ready_back", longint'(if4.in_ready), 1);
        end
    end

    task automatic send4(input int v);
        bit ok = 1'b0;
        if4.in_data  = 16'(v);
        if4.in_valid = 1'b1;
        for (int i = 0; i < 64 && !ok; i++) begin
            @(negedge clk);
            ok = if4.in_ready;
            @(posedge clk);
            #1;
        end
        if4.in_valid = 1'b0;
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL send_timeout_u4: got no in_ready expected accept of %0d", v);
        end
    endtask

    task automatic send5(input int v);
        bit ok = 1'b0;
        if5.in_data  = 16'(v);
        if5.in_valid = 1'b1;
        for (int i = 0; i < 64 && !ok; i++) begin
            @(negedge clk);
            ok = if5.in_ready;
            @(posedge clk);
            #1;
        end
        if5.in_valid = 1'b0;
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL send_timeout_u5: got no in_ready expected accept of %0d", v);
        end
    endtask

    task automatic frame4(input int base);
        push(0, base + 5, 0, 0);
        push(0, base + 7, 0, 1);
        push(0, base + 13, 1, 0);
        push(0, base + 15, 1, 1);
        for (int i = 0; i < 16; i++) send4(base + i);
    endtask

    task automatic frame5(input int base);
        push(1, base + 6, 0, 0);
        push(1, base + 8, 0, 1);
        push(1, base + 16, 1, 0);
        push(1, base + 18, 1, 1);
        for (int i = 0; i < 25; i++) send5(base + i);
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && (q[0].size() != 0 || q[1].size() != 0); i++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        if4.in_data = 16'sd0; if4.in_valid = 1'b0; if4.out_ready = 1'b1;
        if5.in_data = 16'sd0; if5.in_valid = 1'b0; if5.out_ready = 1'b1;
        fd_exp[0] = 1'b0; fd_exp[1] = 1'b0;
        fd_cnt[0] = 0;    fd_cnt[1] = 0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", longint'(if4.in_ready), 0);
        check("rst_out_valid", longint'(if4.out_valid), 0);
        check("rst_out_data", longint'(if4.out_data), 0);
        check("rst_frame_done", longint'(if4.frame_done), 0);
        check("rst_out_row", longint'(if4.out_row), 0);
        check("rst_out_col", longint'(if4.out_col), 0);
        check("rst_in_ready_u5", longint'(if5.in_ready), 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("in_ready_before_edge", longint'(if4.in_ready), 0);
        @(posedge clk);
        #1;
        check("in_ready_after_edge", longint'(if4.in_ready), 1);

        // OUT=5: odd side, last column/row discarded, then next frame restarts at (0,0)
        frame5(0);
        frame5(50);
        drain();

        // OUT=4: plain frame, backpressured frame, all-negative frame
        frame4(0);
        drain();
        bp_arm = 1'b1;
        frame4(0);
        drain();
        frame4(-16);
        drain();

        // Reset mid-frame: only the two windows completed before reset are expected
        push(0, 5, 0, 0);
        push(0, 7, 0, 1);
        for (int i = 0; i < 10; i++) send4(i);
        drain();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("midrst_out_valid", longint'(if4.out_valid), 0);
        check("midrst_in_ready", longint'(if4.in_ready), 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        frame4(0);
        drain();

        // Back-to-back frames with no idle gap
        frame4(0);
        frame4(100);
        drain();

        check("queue_empty_u4", longint'(q[0].size()), 0);
        check("queue_empty_u5", longint'(q[1].size()), 0);
        check("frame_done_count_u4", longint'(fd_cnt[0]), 6);
        check("frame_done_count_u5", longint'(fd_cnt[1]), 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
